// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared frame sizes, FSM state encoding and command codes for the SPI slave
package spi_pkg;

    localparam int SPI_FRAME_W = 10;
    localparam int SPI_DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } spi_state_e;

    typedef logic [1:0] spi_cmd_t;

    localparam spi_cmd_t CMD_WR_ADDR = 2'b00;
    localparam spi_cmd_t CMD_WR_DATA = 2'b01;
    localparam spi_cmd_t CMD_RD_ADDR = 2'b10;
    localparam spi_cmd_t CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// rtl/spi_tx_serializer.sv - loads one read byte and shifts it out on MISO, MSB first
module spi_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              miso_q;

    // The load edge only captures the byte; bit 7 appears on MISO one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
        end else if (clear_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
        end else if (load_i && !busy_q) begin
            shreg_q <= data_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            miso_q  <= 1'b0;
        end else if (busy_q) begin
            if (cnt_q != CNT_END) begin
                miso_q  <= shreg_q[DATA_W-1];
                shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
                cnt_q   <= cnt_q + CNT_ONE;
            end else begin
                miso_q <= 1'b0;
                busy_q <= 1'b0;
            end
        end
    end

    assign miso_o = miso_q;
    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CNT_END);

endmodule

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave front-end: frame FSM, rx deserialiser and read-address tracking
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int FRAME_W = SPI_FRAME_W,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    spi_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rd_seen_q, rd_seen_d;
    logic               tx_started_q, tx_started_d;

    logic               tx_load;
    logic               tx_clear;
    logic               tx_busy;
    logic               tx_done;
    logic [FRAME_W-1:0] shift_in;

    assign shift_in = {shift_q[FRAME_W-2:0], MOSI};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rd_seen_q    <= 1'b0;
            tx_started_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rd_seen_q    <= rd_seen_d;
            tx_started_q <= tx_started_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rd_seen_d    = rd_seen_q;
        tx_started_d = tx_started_q;
        tx_load      = 1'b0;
        tx_clear     = 1'b0;

        // Deselect ends or aborts any frame; an unfinished frame leaves no trace.
        if (state_q != ST_IDLE && SS_n) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            tx_started_d = 1'b0;
            tx_clear     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!SS_n) begin
                        state_d = ST_CHK_CMD;
                        cnt_d   = '0;
                    end
                end
                ST_CHK_CMD: begin
                    cnt_d        = '0;
                    tx_started_d = 1'b0;
                    if (!MOSI)          state_d = ST_WRITE;
                    else if (!rd_seen_q) state_d = ST_READ_ADD;
                    else                state_d = ST_READ_DATA;
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (cnt_q != CNT_FULL) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            if (state_q == ST_READ_ADD) rd_seen_d = 1'b1;
                        end
                    end else if (state_q == ST_READ_DATA) begin
                        if (!tx_started_q && !tx_busy && tx_valid) begin
                            tx_load      = 1'b1;
                            tx_started_d = 1'b1;
                        end
                        if (tx_done) rd_seen_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (tx_clear),
        .load_i  (tx_load),
        .data_i  (tx_data),
        .miso_o  (MISO),
        .busy_o  (tx_busy),
        .done_o  (tx_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - scoreboard bench for spi_slave_if with directed frames
module tb_spi_slave_if;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         start;
        logic [7:0] b;
    } win_t;

    logic [9:0] rx_exp_q[$];
    win_t       win_q[$];

    spi_slave_if #(
        .FRAME_W (10),
        .DATA_W  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame monitor: every rx_valid strobe must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rx_valid !== 1'b0) begin
            if (rx_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rx_valid actual=%0h required=none (cycle %0d)", rx_data, cyc);
            end else begin
                check("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
            end
        end
    end

    // MISO monitor: 0 everywhere except inside an expected 8-bit shift window.
    always @(negedge clk) begin
        logic e;
        e = 1'b0;
        while (win_q.size() > 0 && cyc >= win_q[0].start + 8) void'(win_q.pop_front());
        if (win_q.size() > 0 && cyc >= win_q[0].start)
            e = win_q[0].b[7 - (cyc - win_q[0].start)];
        check("miso", 32'(MISO), 32'(e));
    end

    task automatic drive(input logic ss, input logic m);
        @(negedge clk);
        SS_n = ss;
        MOSI = m;
    endtask

    task automatic wr_frame(input logic sel, input logic [9:0] pl, input int nbits, input int extra);
        if (nbits == 10) rx_exp_q.push_back(pl);
        drive(1'b0, 1'b0);
        drive(1'b0, sel);
        for (int i = 0; i < nbits; i++) drive(1'b0, pl[9-i]);
        for (int i = 0; i < extra; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
    endtask

    task automatic rd_frame(input logic [9:0] pl, input logic [7:0] b, input int hold, input bit exp_tx);
        rx_exp_q.push_back(pl);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, pl[9-i]);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        if (exp_tx) win_q.push_back('{cyc + 2, b});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) tx_data = ~b;
            if (k >= hold) tx_valid = 1'b0;
        end
        drive(1'b1, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #2;
        check("reset_miso", 32'(MISO), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        wr_frame(1'b0, 10'h0A5, 10, 0);
        wr_frame(1'b1, 10'h23C, 10, 0);
        rd_frame({CMD_RD_DATA, 8'h00}, 8'hC3, 9, 1'b1);
        rd_frame({CMD_RD_DATA, 8'hFF}, 8'h5A, 9, 1'b0);
        rd_frame({CMD_RD_DATA, 8'h01}, 8'h81, 1, 1'b1);

        wr_frame(1'b0, 10'h155, 5, 0);
        @(negedge clk);
        check("abort_rx_data_held", 32'(rx_data), 32'h301);

        wr_frame(1'b0, {CMD_WR_DATA, 8'hFE}, 10, 0);
        wr_frame(1'b0, {CMD_WR_ADDR, 8'h12}, 10, 0);
        wr_frame(1'b0, 10'h0C7, 10, 3);

        wr_frame(1'b1, {CMD_RD_ADDR, 8'hAA}, 10, 0);
        wr_frame(1'b1, 10'h3F0, 4, 0);
        rd_frame({CMD_RD_DATA, 8'hC3}, 8'h3C, 9, 1'b1);

        wr_frame(1'b1, {CMD_RD_ADDR, 8'hF0}, 10, 0);
        rx_exp_q.push_back(10'h3E1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, (10'h3E1 >> (9 - i)) & 1'b1);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        win_q.push_back('{cyc + 2, 8'hA5});
        repeat (4) @(negedge clk);
        #2;
        rst_n    = 1'b0;
        win_q.delete();
        tx_valid = 1'b0;
        SS_n     = 1'b1;
        #1;
        check("rst_mid_miso", 32'(MISO), 32'h0);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_mid_rx_data", 32'(rx_data), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        rd_frame({CMD_RD_DATA, 8'hAB}, 8'hFF, 9, 1'b0);

        repeat (3) @(negedge clk);
        check("rx_pending", 32'(rx_exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
